blit_loop_ctl: RTL
==================

Name: blit_loop_ctl

Overview:
- Blitter loop sequencer; drives the outer-count register (countld, ocntena) and consumes its zero flag (outer0).
- Owns the inner-loop counter and handshakes with the inner pixel/phrase engine, one step per inner iteration.
- Emits a per-row address-update pulse and a completion pulse to GPU/interrupt logic.
- Sits in Tom beside the outer counter; runs on the blitter clock domain.

Parameters:
- CW, 16, width of inner count field and outer count field (inner = gpu_din[CW-1:0], outer = gpu_din[2*CW-1:CW]).

Ports:
- clk  in  1  blitter clock.
- reset  in  1  synchronous, active-high reset.
- gpu_din  in  32  GPU write data; low CW bits = inner count, high CW bits consumed by the outer counter.
- cmd_ld  in  1  GPU write strobe to the loop-count register.
- go  in  1  start-blit strobe.
- outer0  in  1  outer counter is zero; registered in the outer counter, updates the cycle after countld/ocntena.
- step_ack  in  1  inner engine completed the current step.
- countld  out  1  outer counter load enable.
- ocntena  out  1  outer counter decrement enable, 1-cycle pulse.
- istep  out  1  request one inner step.
- outer_upd  out  1  row-end address-update pulse.
- busy  out  1  sequence in progress.
- done  out  1  1-cycle completion pulse.
- icount  out  CW  current inner count, for debug/readback.

Behaviour:
- Reset:
  - state=IDLE; icount=0; inner_init=0.
  - All pulse outputs low; busy=0; done=0.
  - An in-flight sequence is abandoned with no done pulse.
- countld:
  - Combinational: countld = cmd_ld & (state==IDLE), so the outer counter samples the same gpu_din.
  - On the same edge, inner_init <= gpu_din[CW-1:0].
  - cmd_ld while busy is ignored entirely: no countld, no inner_init change.
- States: IDLE, CHK, INNER, OUPD, DONE. busy=1 in every state except IDLE.
- IDLE:
  - go moves to CHK.
  - go together with cmd_ld in the same cycle: the load takes effect and go is ignored, because outer0 is not yet valid.
- CHK:
  - outer0=1 -> DONE.
  - Else icount <= inner_init.
  - inner_init==0 -> OUPD (empty row); otherwise -> INNER.
- INNER:
  - istep=1 combinationally.
  - On step_ack: icount <= icount-1.
  - If icount==1 at that ack -> OUPD, else stay in INNER.
  - step_ack while not in INNER is ignored.
- OUPD (exactly 1 cycle):
  - outer_upd=1 and ocntena=1.
  - -> CHK. The decremented outer0 is visible in CHK.
- DONE (1 cycle):
  - done=1.
  - -> IDLE. icount holds its last value.
- Latency and counts:
  - go to first istep: 2 cycles (IDLE->CHK->INNER).
  - For an outer count N>0 and inner count M>0: exactly N*M acks consumed, N outer_upd pulses, one done.
  - A go seen in IDLE with outer count 0 produces done 2 cycles after go and no istep.
- Wrap-around: the outer counter is never decremented at zero, because CHK gates entry to any state that pulses ocntena.
- go while busy: ignored.

Optional Feature:
- Macro: BLIT_LOOP_ABORT_EN.
- With the macro defined:
  - Adds input port abort (1 bit).
  - abort in any state other than IDLE forces DONE next cycle; done still pulses once.
  - istep, ocntena and outer_upd drop in the same cycle abort is seen.
  - abort has priority over step_ack.
- Without the macro: port absent; the sequence always runs to completion.

Test Plan:
- Bench requirement: model the outer counter (load on countld, decrement on ocntena, registered outer0).
- Reset mid-INNER:
  - Stimulus: load 0x0002_0003, go, 2 acks, then assert reset.
  - Required: busy=0, icount=0, no done pulse, no istep after reset.
- Nominal:
  - Stimulus: cmd_ld gpu_din=0x0002_0003, go, step_ack every cycle.
  - Required: 6 acks consumed, outer_upd pulses after acks 3 and 6, 2 ocntena pulses, done once, busy falls the cycle after done.
- Zero outer:
  - Stimulus: cmd_ld 0x0000_0005, go.
  - Required: done exactly 2 cycles after go, no istep, no ocntena.
- Zero inner:
  - Stimulus: cmd_ld 0x0003_0000, go.
  - Required: 3 outer_upd pulses, 0 istep, done once.
- Busy protection:
  - Stimulus: during a 0x0001_0004 blit with slow acks (1 every 4 cycles), issue cmd_ld 0x0009_0009 and go.
  - Required: countld stays 0, the sequence still consumes exactly 4 acks, single done.
- Abort (BLIT_LOOP_ABORT_EN defined):
  - Stimulus: during 0x0004_0004, abort after 5 acks.
  - Required: done next cycle, istep low in the abort cycle, at most 1 ocntena so far, return to IDLE.

Source files
------------

// File: rtl/blit_loop_ctl.sv
// blit_loop_ctl: blitter loop sequencer.
// Walks rows (outer count, held in an external counter that reports outer0)
// and inner steps (icount, owned here), handing one step at a time to the
// inner pixel/phrase engine. Pulses outer_upd at each row end and done once
// at the end of a sequence.
//
// Optional feature: define BLIT_LOOP_ABORT_EN to add an abort input that
// cuts a running sequence short and still signals done once.
//
// Handshake: istep is a level request held for every cycle spent in INNER.
// Each cycle with istep=1 and step_ack=1 consumes exactly one inner step.
// step_ack outside INNER is ignored.
module blit_loop_ctl #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   gpu_din,
   input  logic          cmd_ld,
   input  logic          go,
   input  logic          outer0,
   input  logic          step_ack,
`ifdef BLIT_LOOP_ABORT_EN
   input  logic          abort,
`endif
   output logic          countld,
   output logic          ocntena,
   output logic          istep,
   output logic          outer_upd,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] icount
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHK   = 3'd1,
      INNER = 3'd2,
      OUPD  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] icount_nxt;
   logic [CW-1:0] inner_init;
   logic          abort_hit;

   // The outer count half of gpu_din belongs to the outer counter.
   logic unused_outer_bits;
   assign unused_outer_bits = ^gpu_din[31:CW];

   // A load is only honoured in IDLE; the outer counter samples the same
   // gpu_din on the same edge, so both halves stay consistent.
   assign countld = cmd_ld & (state == IDLE);
   assign busy    = (state != IDLE);

`ifdef BLIT_LOOP_ABORT_EN
   // DONE is excluded so that an abort arriving during the done cycle
   // cannot produce a second done pulse.
   assign abort_hit = abort & (state != IDLE) & (state != DONE);
`else
   assign abort_hit = 1'b0;
`endif

   // Next-state and output decode for the loop sequencer.
   always_comb begin
      state_nxt  = state;
      icount_nxt = icount;
      istep      = 1'b0;
      ocntena    = 1'b0;
      outer_upd  = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            // go alongside cmd_ld is dropped: outer0 does not yet reflect
            // the new load.
            if (go && !cmd_ld) state_nxt = CHK;
         end
         CHK: begin
            if (outer0) begin
               state_nxt = DONE;
            end else begin
               icount_nxt = inner_init;
               state_nxt  = (inner_init == '0) ? OUPD : INNER;
            end
         end
         INNER: begin
            istep = 1'b1;
            if (step_ack) begin
               icount_nxt = icount - 1'b1;
               if (icount == CW'(1)) state_nxt = OUPD;
            end
         end
         OUPD: begin
            // Only reachable through CHK with outer0=0, so the outer
            // counter is never decremented through zero.
            outer_upd = 1'b1;
            ocntena   = 1'b1;
            state_nxt = CHK;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Abort wins over step_ack and suppresses this cycle's pulses.
      if (abort_hit) begin
         state_nxt  = DONE;
         icount_nxt = icount;
         istep      = 1'b0;
         ocntena    = 1'b0;
         outer_upd  = 1'b0;
      end
   end

   // State, inner counter and inner reload value registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         icount     <= '0;
         inner_init <= '0;
      end else begin
         state  <= state_nxt;
         icount <= icount_nxt;
         if (countld) inner_init <= gpu_din[CW-1:0];
      end
   end

endmodule
